// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared types and constants for the I2C slave controller.
//   i2c_state_t : byte-level protocol states
//   I2C_ACK/NACK, OSEL_ACK/DATA : encodings seen by the output mux
package i2c_slave_ctrl_pkg;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BITCNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic OSEL_ACK  = 1'b0;
    localparam logic OSEL_DATA = 1'b1;

endpackage

// File: rtl/i2c_cond_det.sv
// SCL edge and START/STOP condition detector.
//   clk, rst      : system clock, async active-high reset
//   scl_i, sda_i  : synchronized bus lines
//   scl_rise_c_o  : SCL low->high this cycle
//   scl_fall_c_o  : SCL high->low this cycle
//   start_c_o     : SDA falls while SCL held high
//   stop_c_o      : SDA rises while SCL held high
// Outputs are single-cycle combinational pulses off the previous sample.
module i2c_cond_det (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_c_o,
    output logic scl_fall_c_o,
    output logic start_c_o,
    output logic stop_c_o
);

    logic scl_q;
    logic sda_q;

    // Previous samples; reset to the idle-high bus level so no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign scl_rise_c_o = scl_i & ~scl_q;
    assign scl_fall_c_o = ~scl_i & scl_q;
    assign start_c_o    = scl_i & scl_q & sda_q & ~sda_i;
    assign stop_c_o     = scl_i & scl_q & ~sda_q & sda_i;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave bit/byte controller feeding the SDA output mux.
//   clk, rst     : system clock, async active-high reset
//   scl_in/sda_in: synchronized bus lines
//   tx_data_in   : read byte, captured when a read byte is loaded
//   oe_out/osel_out/ack_out/sd_out : drive controls for the output mux
//   rx_data_out/rx_valid_out       : received write byte and its strobe
//   tx_req_out   : pulse after each read-byte load, asks for the next byte
//   busy_out     : addressed and engaged in a transfer
module i2c_slave_ctrl
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter bit                ACK_WRITES = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    input  logic [BYTE_W-1:0] tx_data_in,
    output logic              oe_out,
    output logic              osel_out,
    output logic              ack_out,
    output logic              sd_out,
    output logic [BYTE_W-1:0] rx_data_out,
    output logic              rx_valid_out,
    output logic              tx_req_out,
    output logic              busy_out
);

    localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(BYTE_W - 1);

    logic scl_rise_c;
    logic scl_fall_c;
    logic start_c;
    logic stop_c;

    i2c_cond_det u_cond_det (
        .clk          (clk),
        .rst          (rst),
        .scl_i        (scl_in),
        .sda_i        (sda_in),
        .scl_rise_c_o (scl_rise_c),
        .scl_fall_c_o (scl_fall_c),
        .start_c_o    (start_c),
        .stop_c_o     (stop_c)
    );

    i2c_state_t          state_q,     state_d;
    logic [BITCNT_W-1:0] bitcnt_q,    bitcnt_d;
    logic                byte_done_q, byte_done_d;
    logic [BYTE_W-1:0]   shreg_q,     shreg_d;
    logic                rw_q,        rw_d;
    logic                mack_q,      mack_d;
    logic                oe_q,        oe_d;
    logic                osel_q,      osel_d;
    logic                ack_q,       ack_d;
    logic                sd_q,        sd_d;
    logic [BYTE_W-1:0]   rx_data_q,   rx_data_d;
    logic                rx_valid_q,  rx_valid_d;
    logic                tx_req_q,    tx_req_d;
    logic                busy_q,      busy_d;
    logic                load_c;

    // Next-state and output logic; STOP beats START beats bit events.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        byte_done_d = byte_done_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        oe_d        = oe_q;
        osel_d      = osel_q;
        ack_d       = ack_q;
        sd_d        = sd_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy_q;
        load_c      = 1'b0;

        if (stop_c) begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
            bitcnt_d    = '0;
            byte_done_d = 1'b0;
        end else if (start_c) begin
            state_d     = ADDR;
            oe_d        = 1'b0;
            bitcnt_d    = '0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise_c) begin
                        shreg_d  = {shreg_q[BYTE_W-2:0], sda_in};
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == BIT_LAST) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall_c && byte_done_q) begin
                        // byte_done gates out the SCL fall that follows START
                        byte_done_d = 1'b0;
                        if (shreg_q[BYTE_W-1:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = shreg_q[0];
                            oe_d    = 1'b1;
                            osel_d  = OSEL_ACK;
                            ack_d   = I2C_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (rw_q) begin
                            load_c = 1'b1;
                        end else begin
                            state_d  = WR_DATA;
                            oe_d     = 1'b0;
                            bitcnt_d = '0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise_c) begin
                        shreg_d  = {shreg_q[BYTE_W-2:0], sda_in};
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == BIT_LAST) begin
                            rx_data_d   = {shreg_q[BYTE_W-2:0], sda_in};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall_c && byte_done_q) begin
                        state_d     = WR_ACK;
                        byte_done_d = 1'b0;
                        oe_d        = 1'b1;
                        osel_d      = OSEL_ACK;
                        ack_d       = ACK_WRITES ? I2C_ACK : I2C_NACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_c) begin
                        state_d  = WR_DATA;
                        oe_d     = 1'b0;
                        bitcnt_d = '0;
                    end
                end
                RD_DATA: begin
                    if (scl_fall_c) begin
                        if (bitcnt_q == BIT_LAST) begin
                            state_d  = RD_ACK;
                            oe_d     = 1'b0;
                            bitcnt_d = '0;
                        end else begin
                            shreg_d  = {shreg_q[BYTE_W-2:0], 1'b0};
                            sd_d     = shreg_q[BYTE_W-2];
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise_c) begin
                        mack_d = sda_in;
                    end else if (scl_fall_c) begin
                        if (mack_q == I2C_ACK) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            // Read-byte load: first bit goes out right away, remaining 7 shift on falls.
            if (load_c) begin
                state_d  = RD_DATA;
                shreg_d  = tx_data_in;
                sd_d     = tx_data_in[BYTE_W-1];
                oe_d     = 1'b1;
                osel_d   = OSEL_DATA;
                bitcnt_d = '0;
                tx_req_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
            shreg_q     <= '0;
            rw_q        <= 1'b0;
            mack_q      <= I2C_NACK;
            oe_q        <= 1'b0;
            osel_q      <= OSEL_ACK;
            ack_q       <= I2C_NACK;
            sd_q        <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            byte_done_q <= byte_done_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            oe_q        <= oe_d;
            osel_q      <= osel_d;
            ack_q       <= ack_d;
            sd_q        <= sd_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
        end
    end

    assign oe_out       = oe_q;
    assign osel_out     = osel_q;
    assign ack_out      = ack_q;
    assign sd_out       = sd_q;
    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;
    assign tx_req_out   = tx_req_q;
    assign busy_out     = busy_q;

endmodule
